// File: rtl/mem_pkg.sv
// Shared opcodes, FSM states and lane constants for the M-stage data-memory unit.
// Build option ADDR_ERR_EN enables trapping of misaligned accesses.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] BE_B   = 4'b0001;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unknown opcodes fall back to a word access.
  function automatic size_t accSize(
    input logic [5:0] op,
    input logic       we
  );
    size_t s;
    s = SZ_W;
    if (we) begin
      unique case (1'b1)
        (op == OP_SB): s = SZ_B;
        (op == OP_SH): s = SZ_H;
        default:       s = SZ_W;
      endcase
    end else begin
      unique case (1'b1)
        (op == OP_LB),
        (op == OP_LBU): s = SZ_B;
        (op == OP_LH),
        (op == OP_LHU): s = SZ_H;
        default:        s = SZ_W;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of a 32-bit bus word.
// Pure combinational; halfword select ignores lo[0].
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [5:0]  op,
  output logic [31:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (lo)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  assign h = lo[1] ? rdata[31:16]
                   : rdata[15:0];

  always_comb begin
    ext = rdata;
    unique case (1'b1)
      (op == OP_LB):  ext = {{24{b[7]}}, b};
      (op == OP_LBU): ext = {24'h0, b};
      (op == OP_LH):  ext = {{16{h[15]}}, h};
      (op == OP_LHU): ext = {16'h0, h};
      default:        ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit: req/ack bus master with pipeline stall.
// Build option ADDR_ERR_EN traps misaligned accesses instead of aligning them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [31:0]       EXResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  output logic              addr_err,
  output logic [31:0]       bad_vaddr
);

  localparam int CW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] CNT_MAX =
    CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t        state, nxt;
  logic          memop;
  size_t         sz;
  logic [3:0]    issueBe;
  logic [31:0]   issueWd;
  logic          misErr;
  logic          toHit;
  logic [CW-1:0] cnt;
  logic [5:0]    opQ;
  logic [1:0]    loQ;
  logic          weQ;
  logic [31:0]   vaddrQ;
  logic [31:0]   ext;

  assign memop = MemReadM | MemWriteM;
  assign sz    = accSize(opM, MemWriteM);

  always_comb begin
    issueBe = BE_W;
    issueWd = 32'h0;
    if (MemWriteM) begin
      unique case (sz)
        SZ_B: begin
          issueBe = BE_B << EXResultM[1:0];
          issueWd = {4{WriteDataM[7:0]}};
        end
        SZ_H: begin
          issueBe = EXResultM[1] ? BE_HHI
                                 : BE_HLO;
          issueWd = {2{WriteDataM[15:0]}};
        end
        default: begin
          issueBe = BE_W;
          issueWd = WriteDataM;
        end
      endcase
    end
  end

`ifdef ADDR_ERR_EN
  logic mis;
  always_comb begin
    mis = 1'b0;
    unique case (sz)
      SZ_H:    mis = EXResultM[0];
      SZ_W:    mis = |EXResultM[1:0];
      default: mis = 1'b0;
    endcase
  end
  assign misErr = mis;
`else
  assign misErr = 1'b0;
`endif

  assign toHit = TO_EN && (cnt == CNT_MAX);

  load_extend uExt (
    .rdata (bus_rdata),
    .lo    (loQ),
    .op    (opQ),
    .ext   (ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (memop) nxt = misErr ? DONE : REQ;
      REQ:  if (bus_ack || toHit) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Reset also masks the stall so a held memop cannot freeze the pipe.
  always_comb begin
    bus_req   = (state == REQ);
    mem_stall = rst &
      (((state == IDLE) & memop) | (state == REQ));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ReadDataM <= 32'h0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= '0;
      bus_wdata <= 32'h0;
      bus_err   <= 1'b0;
      addr_err  <= 1'b0;
      bad_vaddr <= 32'h0;
      cnt       <= '0;
      opQ       <= 6'h0;
      loQ       <= 2'h0;
      weQ       <= 1'b0;
      vaddrQ    <= 32'h0;
    end else begin
      bus_err  <= 1'b0;
      addr_err <= 1'b0;
      unique case (state)
        IDLE: if (memop) begin
          cnt <= '0;
          opQ <= opM;
          loQ <= EXResultM[1:0];
          weQ <= MemWriteM;
          if (misErr) begin
            addr_err  <= 1'b1;
            bad_vaddr <= EXResultM;
            ReadDataM <= 32'h0;
          end else begin
            bus_we    <= MemWriteM;
            bus_be    <= issueBe;
            bus_addr  <= {EXResultM[ADDR_W-1:2], 2'b00};
            bus_wdata <= issueWd;
            vaddrQ    <= EXResultM;
          end
        end
        REQ: begin
          if (bus_ack) begin
            ReadDataM <= weQ ? 32'h0 : ext;
          end else if (toHit) begin
            bus_err   <= 1'b1;
            ReadDataM <= 32'h0;
            bad_vaddr <= vaddrQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural bus responder.
// Honours ADDR_ERR_EN to pick misaligned-access expectations.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opM;
  logic        MemReadM, MemWriteM;
  logic [31:0] EXResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        mem_stall, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, bus_err, addr_err;
  logic [31:0] bad_vaddr;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opM        (opM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .EXResultM  (EXResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .mem_stall  (mem_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err),
    .addr_err   (addr_err),
    .bad_vaddr  (bad_vaddr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic        berr;
    logic        aerr;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] expBad = 32'h0;

  function automatic int sizeOf(
    input logic [5:0] op,
    input logic       we
  );
    if (we) begin
      if (op == OP_SB) return 1;
      if (op == OP_SH) return 2;
      return 4;
    end
    if (op == OP_LB || op == OP_LBU) return 1;
    if (op == OP_LH || op == OP_LHU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] refLoad(
    input logic [5:0]  op,
    input logic [1:0]  lo,
    input logic [31:0] d
  );
    logic [31:0] s;
    logic [15:0] h;
    s = d >> (8 * lo);
    h = lo[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   return {{24{s[7]}}, s[7:0]};
      OP_LBU:  return {24'h0, s[7:0]};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  task automatic access(
    input logic [5:0]  op,
    input logic        rd,
    input logic        wr,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rdata,
    input int          ackLat
  );
    exp_t e, g;
    int   sz, stalls, reqs;
    logic mis, done;
    sz  = sizeOf(op, wr);
    mis = 1'b0;
`ifdef ADDR_ERR_EN
    mis = (sz == 2 && a[0]) ||
          (sz == 4 && a[1:0] != 2'b00);
`endif
    e.we = wr;
    e.be = 4'hF;
    e.wd = wd;
    if (wr && sz == 1) begin
      e.be = 4'b0001 << a[1:0];
      e.wd = {4{wd[7:0]}};
    end else if (wr && sz == 2) begin
      e.be = a[1] ? 4'b1100 : 4'b0011;
      e.wd = {2{wd[15:0]}};
    end
    e.addr   = {a[31:2], 2'b00};
    e.aerr   = mis;
    e.berr   = !mis && ackLat >= TO;
    e.rd     = (mis || e.berr || wr) ? 32'h0
             : refLoad(op, a[1:0], rdata);
    e.stalls = mis ? 1 : e.berr ? TO + 1 : ackLat + 2;
    e.reqs   = mis ? 0 : e.berr ? TO : ackLat + 1;
    if (mis || e.berr) expBad = a;
    sb.push_back(e);

    opM = op; MemReadM = rd; MemWriteM = wr;
    EXResultM = a; WriteDataM = wd;
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus_req) begin
        if (reqs == 0) begin
          check("we", bus_we, e.we);
          check("be", bus_be, e.be);
          check("addr", bus_addr, e.addr);
          if (wr) check("wdata", bus_wdata, e.wd);
        end
        if (reqs == ackLat) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
        reqs++;
      end
      if (mem_stall) stalls++;
      else begin
        done = 1'b1;
        bus_ack = 1'b0;
        g = sb.pop_front();
        check("rdata", ReadDataM, g.rd);
        check("stalls", stalls, g.stalls);
        check("reqs", reqs, g.reqs);
        check("berr", bus_err, g.berr);
        check("aerr", addr_err, g.aerr);
        check("badva", bad_vaddr, expBad);
        check("doneReq", bus_req, 0);
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      check("noDone", 0, 1);
      sb.delete();
    end
    bus_ack = 1'b0;
    @(negedge clk);
    MemReadM = 1'b0; MemWriteM = 1'b0;
    #1;
    check("hold", ReadDataM, e.rd);
    check("idleStall", mem_stall, 0);
    check("idleBerr", bus_err, 0);
  endtask

  initial begin
    rst = 1'b0;
    opM = 6'h0; MemReadM = 1'b0; MemWriteM = 1'b0;
    EXResultM = 32'h0; WriteDataM = 32'h0;
    bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rstRd", ReadDataM, 0);
    check("rstReq", bus_req, 0);
    check("rstBe", bus_be, 0);
    check("rstAddr", bus_addr, 0);
    check("rstStall", mem_stall, 0);
    check("rstBad", bad_vaddr, 0);
    check("rstAerr", addr_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    access(OP_LW,  1, 0, 32'h100, 0, 32'hDEADBEEF, 0);
    access(OP_LB,  1, 0, 32'h103, 0, 32'h80FF1234, 0);
    access(OP_LBU, 1, 0, 32'h103, 0, 32'h80FF1234, 1);
    access(OP_LH,  1, 0, 32'h102, 0, 32'h80010000, 0);
    access(OP_LHU, 1, 0, 32'h102, 0, 32'h80010000, 2);
    access(OP_LB,  1, 0, 32'h101, 0, 32'h00007F00, 0);
    access(OP_SH,  0, 1, 32'h206, 32'h0000ABCD, 0, 3);
    access(OP_SB,  0, 1, 32'h301, 32'h0000005A, 0, 0);
    access(OP_LW,  1, 0, 32'h400, 0, 32'h55555555, 99);
    access(OP_LW,  1, 0, 32'h102, 0, 32'h11223344, 1);
    access(OP_SW,  0, 1, 32'h500, 32'hCAFEF00D, 0, 0);
    access(OP_LW,  1, 0, 32'h504, 0, 32'h0BADC0DE, 0);
    access(OP_SW,  1, 1, 32'h508, 32'h12345678, 32'hFFFFFFFF, 1);

    opM = OP_LW; MemReadM = 1'b1; EXResultM = 32'h600;
    @(negedge clk);
    #1;
    check("preRstReq", bus_req, 1);
    rst = 1'b0;
    #1;
    check("midRstReq", bus_req, 0);
    check("midRstStall", mem_stall, 0);
    check("midRstRd", ReadDataM, 0);
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    MemReadM = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("lateAckRd", ReadDataM, 0);
    check("lateAckReq", bus_req, 0);
    check("lateAckStall", mem_stall, 0);
    bus_ack = 1'b0;
    @(negedge clk);
    #1;
    check("postRstReq", bus_req, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
